// File: rtl/conv_pkg.sv
// Shared types for the conv window generator: index triple, FSM states, output-size helper.
package conv_pkg;

  localparam int unsigned INDEX_W = 16;

  // {channel, row, col}; element 2 is the channel, element 0 the column.
  typedef logic [2:0][INDEX_W-1:0] conv_index_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    LAST,
    DONE
  } conv_state_e;

  // Number of window positions along one axis.
  function automatic int unsigned out_dim(input int unsigned input_dim,
                                          input int unsigned kernel_dim,
                                          input int unsigned stride);
    return (input_dim - kernel_dim) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Activation-in / window-out stream bundle for conv_window_gen.
// slave: the window generator; master: the producer/consumer around it.
interface conv_window_gen_if #(
  parameter int unsigned DATA_SIZE  = 64,
  parameter int unsigned KERNEL_DIM = 3
) ();

  logic [DATA_SIZE-1:0]                       in_data;
  conv_pkg::conv_index_t                      in_index;
  logic                                       in_valid;
  logic                                       in_ready;
  logic [KERNEL_DIM*KERNEL_DIM*DATA_SIZE-1:0] out_window;
  conv_pkg::conv_index_t                      out_index;
  logic                                       out_valid;
  logic                                       out_ready;
  logic                                       layer_done;
  logic                                       index_error;

  modport slave (
    input  in_data, in_index, in_valid, out_ready,
    output in_ready, out_window, out_index, out_valid, layer_done, index_error
  );

  modport master (
    output in_data, in_index, in_valid, out_ready,
    input  in_ready, out_window, out_index, out_valid, layer_done, index_error
  );

endinterface

// File: rtl/conv_line_buffer.sv
// KERNEL_DIM-1 row line buffer. Reading a column returns the buffered pixels of the
// previous rows at that column (index 0 = oldest row); a write shifts the column up by one
// and stores the new pixel as the most recent row. Contents need no reset.
module conv_line_buffer #(
  parameter int unsigned DATA_SIZE  = 64,
  parameter int unsigned INPUT_DIM  = 28,
  parameter int unsigned KERNEL_DIM = 3,
  parameter int unsigned ColW       = (INPUT_DIM > 1) ? $clog2(INPUT_DIM) : 1
) (
  input  logic                                   clk,
  input  logic [ColW-1:0]                        col_i,
  input  logic                                   wr_en_i,
  input  logic [DATA_SIZE-1:0]                   wr_data_i,
  output logic [KERNEL_DIM-2:0][DATA_SIZE-1:0]   rd_col_o
);

  logic [DATA_SIZE-1:0] mem_q [KERNEL_DIM-1][INPUT_DIM];

  // Combinational read of every buffered row at the current column.
  always_comb begin
    for (int r = 0; r < int'(KERNEL_DIM) - 1; r++) begin
      rd_col_o[r] = mem_q[r][col_i];
    end
  end

  // Vertical shift of one column on each accepted pixel.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int r = 0; r < int'(KERNEL_DIM) - 2; r++) begin
        mem_q[r][col_i] <= mem_q[r+1][col_i];
      end
      mem_q[KERNEL_DIM-2][col_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding-window generator: raster-order activations in, strided KERNEL_DIM x KERNEL_DIM
// windows out, each tagged with {channel, out_row, out_col}. Single output register with
// valid/ready on both sides.
// Optional build macro INDEX_CHECK_EN: compares in_index against the internal position on
// every accepted beat and raises a sticky index_error on mismatch.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 64,
  parameter int unsigned NUM_INPUTS = 1,
  parameter int unsigned INPUT_DIM  = 28,
  parameter int unsigned KERNEL_DIM = 3,
  parameter int unsigned STRIDE     = 1
) (
  input logic              clk,
  input logic              rst,
  conv_window_gen_if.slave bus
);

  localparam int unsigned OUT_DIM = out_dim(INPUT_DIM, KERNEL_DIM, STRIDE);
  localparam int unsigned ColW    = (INPUT_DIM > 1) ? $clog2(INPUT_DIM) : 1;
  localparam int unsigned ChW     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned OW      = (OUT_DIM > 1) ? $clog2(OUT_DIM + 1) : 1;
  localparam int unsigned PW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [ColW-1:0] DimLast = ColW'(INPUT_DIM - 1);
  localparam logic [ColW-1:0] KLast   = ColW'(KERNEL_DIM - 1);
  localparam logic [ColW-1:0] KPrev   = ColW'(KERNEL_DIM - 2);
  localparam logic [ChW-1:0]  ChLast  = ChW'(NUM_INPUTS - 1);
  localparam logic [PW-1:0]   PhLast  = PW'(STRIDE - 1);

  typedef logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][DATA_SIZE-1:0] window_t;

  conv_state_e            state_q, state_d;
  logic [ColW-1:0]        col_q, col_d, row_q, row_d;
  logic [ChW-1:0]         ch_q, ch_d;
  logic [PW-1:0]          cph_q, cph_d, rph_q, rph_d;
  logic [OW-1:0]          ocol_q, ocol_d, orow_q, orow_d;
  window_t                win_q, win_d;
  window_t                out_win_q, out_win_d;
  conv_index_t            out_idx_q, out_idx_d;
  logic                   out_valid_q, out_valid_d;

  logic                                   in_ready;
  logic                                   accept;
  logic                                   emit;
  logic                                   last_pix;
  logic [KERNEL_DIM-2:0][DATA_SIZE-1:0]   lb_col;
  logic [KERNEL_DIM-1:0][DATA_SIZE-1:0]   new_col;

  // Held off while in reset and whenever a stalled window occupies the output register.
  assign in_ready = !rst && (state_q == IDLE || state_q == STREAM) &&
                    (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign last_pix = (ch_q == ChLast) && (row_q == DimLast) && (col_q == DimLast);
  assign emit     = accept && (row_q >= KLast) && (col_q >= KLast) &&
                    (rph_q == '0) && (cph_q == '0);

  // New right-hand window column: buffered rows on top, the incoming pixel at the bottom.
  assign new_col = {bus.in_data, lb_col};

  conv_line_buffer #(
    .DATA_SIZE  (DATA_SIZE),
    .INPUT_DIM  (INPUT_DIM),
    .KERNEL_DIM (KERNEL_DIM),
    .ColW       (ColW)
  ) u_line_buffer (
    .clk       (clk),
    .col_i     (col_q),
    .wr_en_i   (accept),
    .wr_data_i (bus.in_data),
    .rd_col_o  (lb_col)
  );

  // Next window contents: shift left one column, cleared at every row start.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int kr = 0; kr < int'(KERNEL_DIM); kr++) begin
        for (int kc = 0; kc < int'(KERNEL_DIM) - 1; kc++) begin
          win_d[kr][kc] = (col_q == '0) ? '0 : win_q[kr][kc+1];
        end
        win_d[kr][KERNEL_DIM-1] = new_col[kr];
      end
    end
  end

  // Raster position, stride phases and output-coordinate counters.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    ch_d   = ch_q;
    cph_d  = cph_q;
    rph_d  = rph_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    if (accept) begin
      if (col_q == DimLast) begin
        col_d  = '0;
        cph_d  = '0;
        ocol_d = '0;
        if (row_q == DimLast) begin
          row_d  = '0;
          rph_d  = '0;
          orow_d = '0;
          ch_d   = (ch_q == ChLast) ? '0 : ch_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
          // Phase restarts where the first window row completes.
          if (row_q == KPrev) begin
            rph_d = '0;
          end else begin
            rph_d = (rph_q == PhLast) ? '0 : rph_q + 1'b1;
          end
          if (row_q >= KLast && rph_q == '0) begin
            orow_d = orow_q + 1'b1;
          end
        end
      end else begin
        col_d = col_q + 1'b1;
        if (col_q == KPrev) begin
          cph_d = '0;
        end else begin
          cph_d = (cph_q == PhLast) ? '0 : cph_q + 1'b1;
        end
        if (col_q >= KLast && cph_q == '0) begin
          ocol_d = ocol_q + 1'b1;
        end
      end
    end
  end

  // Output register: load on emit (may coincide with the consumer taking the old one).
  always_comb begin
    out_valid_d = out_valid_q;
    out_win_d   = out_win_q;
    out_idx_d   = out_idx_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_win_d   = win_d;
      out_idx_d   = {INDEX_W'(ch_q), INDEX_W'(orow_q), INDEX_W'(ocol_q)};
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Layer sequencing: stream, drain the final window, one-cycle done pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = last_pix ? LAST : STREAM;
      STREAM:  if (accept && last_pix) state_d = LAST;
      LAST:    if (!out_valid_q || bus.out_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      cph_q       <= '0;
      rph_q       <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
      win_q       <= '0;
      out_win_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      cph_q       <= cph_d;
      rph_q       <= rph_d;
      ocol_q      <= ocol_d;
      orow_q      <= orow_d;
      win_q       <= win_d;
      out_win_q   <= out_win_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_window = out_win_q;
  assign bus.out_index  = out_idx_q;
  assign bus.layer_done = (state_q == DONE);

`ifdef INDEX_CHECK_EN
  logic        err_q, err_d;
  conv_index_t cur_idx;

  assign cur_idx = {INDEX_W'(ch_q), INDEX_W'(row_q), INDEX_W'(col_q)};

  // Sticky flag; the beat is still consumed at the internal position.
  always_comb begin
    err_d = err_q | (accept && (bus.in_index != cur_idx));
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.index_error = err_q;
`else
  logic unused_in_index;
  assign unused_in_index  = ^bus.in_index;
  assign bus.index_error  = 1'b0;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: two instances (2ch/4x4/stride 1 and 1ch/5x5/stride 2) driven
// from one stimulus process, checked against a window list computed from pixel arrays.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned K  = 3;
  localparam int unsigned WW = K * K * DW;
  localparam int A_NI = 2, A_DIM = 4, A_S = 1;
  localparam int B_NI = 1, B_DIM = 5, B_S = 2;

  typedef struct packed {
    logic [WW-1:0] win;
    conv_index_t   idx;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          drv_sel   = 1'b0;
  logic          drv_valid = 1'b0;
  logic          drv_ready = 1'b1;
  logic [DW-1:0] drv_data  = '0;
  conv_index_t   drv_index = '0;

  conv_window_gen_if #(.DATA_SIZE(DW), .KERNEL_DIM(K)) ifa ();
  conv_window_gen_if #(.DATA_SIZE(DW), .KERNEL_DIM(K)) ifb ();

  assign ifa.in_valid  = drv_valid && !drv_sel;
  assign ifa.in_data   = drv_data;
  assign ifa.in_index  = drv_index;
  assign ifa.out_ready = drv_sel ? 1'b1 : drv_ready;
  assign ifb.in_valid  = drv_valid && drv_sel;
  assign ifb.in_data   = drv_data;
  assign ifb.in_index  = drv_index;
  assign ifb.out_ready = drv_sel ? drv_ready : 1'b1;

  logic          obs_valid, obs_in_ready, obs_done, obs_err;
  logic [WW-1:0] obs_window;
  conv_index_t   obs_index;
  assign obs_valid    = drv_sel ? ifb.out_valid   : ifa.out_valid;
  assign obs_in_ready = drv_sel ? ifb.in_ready    : ifa.in_ready;
  assign obs_done     = drv_sel ? ifb.layer_done  : ifa.layer_done;
  assign obs_err      = drv_sel ? ifb.index_error : ifa.index_error;
  assign obs_window   = drv_sel ? ifb.out_window  : ifa.out_window;
  assign obs_index    = drv_sel ? ifb.out_index   : ifa.out_index;

  conv_window_gen #(
    .DATA_SIZE(DW), .NUM_INPUTS(A_NI), .INPUT_DIM(A_DIM), .KERNEL_DIM(K), .STRIDE(A_S)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  conv_window_gen #(
    .DATA_SIZE(DW), .NUM_INPUTS(B_NI), .INPUT_DIM(B_DIM), .KERNEL_DIM(K), .STRIDE(B_S)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [DW-1:0] pix [2][5][5];
  win_t          exp_q [$];
  int            compared   = 0;
  int            mismatched = 0;

`ifdef INDEX_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  // Reference: every window position of every channel, in emission order.
  function automatic void build_expected(input int ni, input int dim, input int s);
    int od;
    win_t e;
    od = (dim - int'(K)) / s + 1;
    exp_q.delete();
    for (int ch = 0; ch < ni; ch++)
      for (int orow = 0; orow < od; orow++)
        for (int ocol = 0; ocol < od; ocol++) begin
          e.win = '0;
          for (int kr = 0; kr < int'(K); kr++)
            for (int kc = 0; kc < int'(K); kc++)
              e.win[(kr*int'(K)+kc)*int'(DW) +: DW] = pix[ch][orow*s+kr][ocol*s+kc];
          e.idx = {16'(ch), 16'(orow), 16'(ocol)};
          exp_q.push_back(e);
        end
  endfunction

  function automatic void fill_ramp(input int dim);
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          pix[ch][r][c] = 64'(ch * 16 + r * dim + c);
  endfunction

  function automatic void fill_random();
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          pix[ch][r][c] = {$urandom(), $urandom()};
  endfunction

  // Drives one layer (or its first stop_after beats) and checks every accepted window.
  task automatic stream(input int sel, input int ni, input int dim, input int s,
                        input int rdy_pct, input int gap_pct, input int stop_after,
                        input int bad_beat, input int hold_first,
                        output int n_win, output int n_done);
    int ch, r, c, beats, cyc, hold, total;
    bit held;
    logic [WW-1:0] held_win;
    win_t e;
    ch = 0; r = 0; c = 0; beats = 0; cyc = 0; hold = 0; held = 0; held_win = '0;
    total = ni * dim * dim;
    n_win = 0;
    n_done = 0;
    build_expected(ni, dim, s);
    drv_sel = (sel != 0);
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        compared++;
        mismatched++;
        $display("FAIL stream_timeout sel=%0d: got %0d beats, layer_done=%0d; want %0d beats and done",
                 sel, beats, n_done, total);
        break;
      end
      if (hold_first != 0 && !held && obs_valid) begin
        held = 1;
        hold = 5;
        held_win = obs_window;
      end
      drv_valid = (beats < total) && ($urandom_range(99) >= gap_pct);
      if (beats < total) begin
        drv_data  = pix[ch][r][c];
        drv_index = {16'(ch), 16'(r), 16'(c)};
        if (beats == bad_beat) drv_index[0] = 16'(c + 1);
      end
      drv_ready = (hold > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      #1;
      if (hold > 0) begin
        compared += 2;
        if (obs_in_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL bp_in_ready: got %b want 0", obs_in_ready);
        end
        if (obs_window !== held_win) begin
          mismatched++;
          $display("FAIL bp_window_stable: got %h want %h", obs_window, held_win);
        end
        hold--;
      end
      if (obs_done === 1'b1) n_done++;
      if (obs_valid === 1'b1 && drv_ready) begin
        n_win++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL extra_window sel=%0d: got index %h want none", sel, obs_index);
        end else begin
          e = exp_q.pop_front();
          compared++;
          if (obs_window !== e.win) begin
            mismatched++;
            $display("FAIL win_data sel=%0d: got %h want %h", sel, obs_window, e.win);
          end
          if (obs_index !== e.idx) begin
            mismatched++;
            $display("FAIL win_index sel=%0d: got %h want %h", sel, obs_index, e.idx);
          end
        end
      end
      if (drv_valid && obs_in_ready === 1'b1) begin
        beats++;
        c++;
        if (c == dim) begin c = 0; r++; end
        if (r == dim) begin r = 0; ch++; end
      end
      if (stop_after >= 0 && beats >= stop_after) break;
      if (n_done > 0) break;
    end
  endtask

  // Common end-of-layer checks: window count, nothing left, done lasts one cycle.
  task automatic check_layer(input string name, input int n_win, input int want_win);
    compared += 3;
    if (n_win != want_win) begin
      mismatched++;
      $display("FAIL %s_count: got %0d windows want %0d", name, n_win, want_win);
    end
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_lost: got %0d windows missing want 0", name, exp_q.size());
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    @(negedge clk);
    #1;
    if (obs_done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_done_pulse: got %b want 0 one cycle after done", name, obs_done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      drv_sel = (sel != 0);
      #1;
      compared += 6;
      if (obs_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b want 0", obs_valid); end
      if (obs_in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready: got %b want 0", obs_in_ready); end
      if (obs_done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b want 0", obs_done); end
      if (obs_err !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b want 0", obs_err); end
      if (obs_window !== '0) begin mismatched++; $display("FAIL rst_window: got %h want 0", obs_window); end
      if (obs_index !== '0) begin mismatched++; $display("FAIL rst_index: got %h want 0", obs_index); end
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    compared++;
    if (obs_in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL idle_in_ready: got %b want 1", obs_in_ready);
    end
  endtask

  task automatic test_basic();
    int nw, nd;
    fill_ramp(A_DIM);
    stream(0, A_NI, A_DIM, A_S, 100, 0, -1, -1, 0, nw, nd);
    check_layer("basic", nw, 8);
    compared++;
    if (obs_err !== 1'b0) begin mismatched++; $display("FAIL basic_err: got %b want 0", obs_err); end
  endtask

  task automatic test_stride();
    int nw, nd;
    fill_ramp(B_DIM);
    stream(1, B_NI, B_DIM, B_S, 100, 0, -1, -1, 0, nw, nd);
    check_layer("stride", nw, 4);
  endtask

  task automatic test_backpressure();
    int nw, nd;
    fill_random();
    stream(0, A_NI, A_DIM, A_S, 100, 0, -1, -1, 1, nw, nd);
    check_layer("backpressure", nw, 8);
  endtask

  task automatic test_channels_random();
    int nw, nd;
    for (int it = 0; it < 3; it++) begin
      fill_random();
      stream(0, A_NI, A_DIM, A_S, 60, 30, -1, -1, 0, nw, nd);
      check_layer("channels", nw, 8);
      fill_random();
      stream(1, B_NI, B_DIM, B_S, 50, 40, -1, -1, 0, nw, nd);
      check_layer("stride_rand", nw, 4);
    end
  endtask

  task automatic test_reset_mid();
    int nw, nd;
    fill_ramp(A_DIM);
    stream(0, A_NI, A_DIM, A_S, 100, 0, 11, -1, 0, nw, nd);
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    compared++;
    if (obs_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_pending: got %b want 1", obs_valid);
    end
    rst = 1'b1;
    #1;
    compared += 3;
    if (obs_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_valid: got %b want 0", obs_valid); end
    if (obs_in_ready !== 1'b0) begin mismatched++; $display("FAIL mid_rst_in_ready: got %b want 0", obs_in_ready); end
    if (obs_window !== '0) begin mismatched++; $display("FAIL mid_rst_window: got %h want 0", obs_window); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    compared += 3;
    if (obs_in_ready !== 1'b1) begin mismatched++; $display("FAIL mid_idle: got %b want 1", obs_in_ready); end
    if (obs_done !== 1'b0) begin mismatched++; $display("FAIL mid_no_done: got %b want 0", obs_done); end
    if (obs_valid !== 1'b0) begin mismatched++; $display("FAIL mid_valid_after: got %b want 0", obs_valid); end
    stream(0, A_NI, A_DIM, A_S, 100, 0, -1, -1, 0, nw, nd);
    check_layer("restart", nw, 8);
  endtask

  task automatic test_index_check();
    int nw, nd;
    fill_ramp(A_DIM);
    stream(0, A_NI, A_DIM, A_S, 100, 0, -1, 2, 0, nw, nd);
    check_layer("idx", nw, 8);
    compared++;
    if (obs_err !== ERR_EXP) begin
      mismatched++;
      $display("FAIL idx_err_set: got %b want %b", obs_err, ERR_EXP);
    end
    fill_random();
    stream(0, A_NI, A_DIM, A_S, 80, 20, -1, -1, 0, nw, nd);
    check_layer("idx_clean", nw, 8);
    compared++;
    if (obs_err !== ERR_EXP) begin
      mismatched++;
      $display("FAIL idx_err_sticky: got %b want %b", obs_err, ERR_EXP);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (obs_err !== 1'b0) begin mismatched++; $display("FAIL idx_err_rst: got %b want 0", obs_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_backpressure();
    test_channels_random();
    test_reset_mid();
    test_index_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
